// File: rtl/fa_bist_ctrl.sv
// BIST controller for a 1-bit full adder: steps all eight {a,b,cin} vectors,
// samples sum/carry after a settle time and reports pass, error count and first failure.
module fa_bist_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  input  logic             sum_i,
  input  logic             carry_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_FINISH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_vec;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W-1:0] w_err_next;
  logic [2:0]       r_ff_vec;
  logic             r_ff_valid;
  logic             r_pass;
  logic             w_exp_sum;
  logic             w_exp_carry;
  logic             w_mismatch;

  assign w_exp_sum   = r_vec[2] ^ r_vec[1] ^ r_vec[0];
  assign w_exp_carry = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_mismatch  = (r_state == S_CHECK) &&
                       ((sum_i != w_exp_sum) || (carry_i != w_exp_carry));
  assign w_err_next  = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    a_o    = 1'b0;
    b_o    = 1'b0;
    c_o    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        {a_o, b_o, c_o} = r_vec;
        if (r_cnt == CNT_LAST) w_next = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        {a_o, b_o, c_o} = r_vec;
        w_next = (r_vec == 3'd7) ? S_FINISH : S_SETTLE;
      end
      S_FINISH: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_vec      <= '0;
      r_err      <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_vec      <= '0;
            r_err      <= '0;
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
            r_pass     <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
        end
        S_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ff_valid) begin
            r_ff_vec   <= r_vec;
            r_ff_valid <= 1'b1;
          end
          // pass is loaded on entry to FINISH so it is already valid alongside done
          if (r_vec == 3'd7) begin
            r_pass <= (w_err_next == '0);
          end else begin
            r_vec <= r_vec + 3'd1;
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pass             = r_pass;
  assign err_cnt          = r_err;
  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Directed bench for fa_bist_ctrl: a behavioural adder with selectable faults,
// plus instances exercising ERR_W=2 saturation and SETTLE_CYCLES=1 timing.
module tb_fa_bist_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] fault;

  logic       start, a_o, b_o, c_o, sum_i, carry_i, busy, done, pass, ff_valid;
  logic [3:0] err_cnt;
  logic [2:0] ff_vec;

  logic       start_w2, a_w2, b_w2, c_w2, busy_w2, done_w2, pass_w2, ffv_w2;
  logic [1:0] err_w2;
  logic [2:0] ff_w2;

  logic       start_s1, a_s1, b_s1, c_s1, busy_s1, done_s1, pass_s1, ffv_s1;
  logic [3:0] err_s1;
  logic [2:0] ff_s1;

  int total;
  int bad;

  // fault 0: correct adder, 1: carry stuck-at-0, 2: inverted sum
  assign sum_i   = a_o ^ b_o ^ c_o ^ (fault == 2'd2);
  assign carry_i = (fault == 2'd1) ? 1'b0 : ((a_o & b_o) | (a_o & c_o) | (b_o & c_o));

  fa_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .sum_i(sum_i), .carry_i(carry_i),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vec(ff_vec), .first_fail_valid(ff_valid)
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(2), .ERR_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_w2),
    .a_o(a_w2), .b_o(b_w2), .c_o(c_w2),
    .sum_i(~(a_w2 ^ b_w2 ^ c_w2)),
    .carry_i((a_w2 & b_w2) | (a_w2 & c_w2) | (b_w2 & c_w2)),
    .busy(busy_w2), .done(done_w2), .pass(pass_w2), .err_cnt(err_w2),
    .first_fail_vec(ff_w2), .first_fail_valid(ffv_w2)
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(1), .ERR_W(4)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s1),
    .a_o(a_s1), .b_o(b_s1), .c_o(c_s1),
    .sum_i(a_s1 ^ b_s1 ^ c_s1),
    .carry_i((a_s1 & b_s1) | (a_s1 & c_s1) | (b_s1 & c_s1)),
    .busy(busy_s1), .done(done_s1), .pass(pass_s1), .err_cnt(err_s1),
    .first_fail_vec(ff_s1), .first_fail_valid(ffv_s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_abc"}, {29'd0, a_o, b_o, c_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
    chk({tag, "_err"}, {28'd0, err_cnt}, 32'd0);
    chk({tag, "_ffvec"}, {29'd0, ff_vec}, 32'd0);
    chk({tag, "_ffvalid"}, {31'd0, ff_valid}, 32'd0);
  endtask

  // Pulses start on the main instance and checks every cycle after edge e (edge 0 = start sampled).
  task automatic run_main(input int poke_edge, input int rst_edge, input bit hold,
                          input bit exp_pass, input int err12);
    int ndone;
    ndone = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold) start = 1'b0;
    for (int e = 0; e <= 27; e++) begin
      if (e == rst_edge) begin
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("rst_mid");
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      if (e < 24) begin
        chk("vec", {29'd0, a_o, b_o, c_o}, e / 3);
        chk("busy_run", {31'd0, busy}, 32'd1);
      end
      chk("done", {31'd0, done}, (e == 24) ? 32'd1 : 32'd0);
      if (e == 12) chk("err_after_v3", {28'd0, err_cnt}, err12);
      if (e == 24) begin
        chk("busy_finish", {31'd0, busy}, 32'd1);
        chk("pass_with_done", {31'd0, pass}, {31'd0, exp_pass});
      end
      if (e == 25) chk("busy_idle", {31'd0, busy}, 32'd0);
      if (e == 26 && hold) chk("busy_b2b", {31'd0, busy}, 32'd1);
      if (poke_edge >= 0 && e == poke_edge) start = 1'b1;
      if (poke_edge >= 0 && e == poke_edge + 1) start = 1'b0;
      ndone += int'(done);
      @(negedge clk);
    end
    chk("done_once", ndone, 32'd1);
    if (hold) begin
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
    end
  endtask

  task automatic chk_results(input string tag, input bit p, input int e,
                             input int fv, input bit fvalid);
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
    chk({tag, "_err"}, {28'd0, err_cnt}, e);
    chk({tag, "_ffvec"}, {29'd0, ff_vec}, fv);
    chk({tag, "_ffvalid"}, {31'd0, ff_valid}, {31'd0, fvalid});
  endtask

  initial begin
    bit seen;
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; start_w2 = 1'b0; start_s1 = 1'b0; fault = 2'd0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fault = 2'd0;
    run_main(-1, -1, 1'b0, 1'b1, 0);
    chk_results("good", 1'b1, 0, 0, 1'b0);

    fault = 2'd1;
    run_main(-1, -1, 1'b0, 1'b0, 1);
    chk_results("carry_sa0", 1'b0, 4, 3, 1'b1);

    fault = 2'd2;
    run_main(-1, -1, 1'b0, 1'b0, 4);
    chk_results("inv_sum", 1'b0, 8, 0, 1'b1);

    fault = 2'd0;
    run_main(10, -1, 1'b0, 1'b1, 0);
    chk_results("poke", 1'b1, 0, 0, 1'b0);

    fault = 2'd1;
    run_main(-1, 13, 1'b0, 1'b0, 1);
    fault = 2'd0;
    run_main(-1, -1, 1'b0, 1'b1, 0);
    chk_results("after_rst", 1'b1, 0, 0, 1'b0);

    run_main(-1, -1, 1'b1, 1'b1, 0);

    @(negedge clk); start_w2 = 1'b1;
    @(negedge clk); start_w2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_w2) seen = 1'b1;
    end
    chk("w2_done_seen", {31'd0, seen}, 32'd1);
    chk("w2_err_sat", {30'd0, err_w2}, 32'd3);
    chk("w2_pass", {31'd0, pass_w2}, 32'd0);
    chk("w2_ffvec", {29'd0, ff_w2}, 32'd0);
    chk("w2_ffvalid", {31'd0, ffv_w2}, 32'd1);

    @(negedge clk); start_s1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_s1 = 1'b0;
    for (int e = 0; e <= 18; e++) begin
      if (e < 16) chk("s1_vec", {29'd0, a_s1, b_s1, c_s1}, e / 2);
      chk("s1_done", {31'd0, done_s1}, (e == 16) ? 32'd1 : 32'd0);
      if (e == 16) chk("s1_pass", {31'd0, pass_s1}, 32'd1);
      @(negedge clk);
    end
    chk("s1_err", {28'd0, err_s1}, 32'd0);
    chk("s1_ffvalid", {31'd0, ffv_s1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fa_bist_ctrl.md
# fa_bist_ctrl

Built-in self-test controller for the lab's 1-bit full adder. On a start request it applies all eight {a,b,cin} input vectors in order to the adder under test. It waits a programmable settle time per vector, then samples sum/carry and compares them against the expected result. It reports pass/fail, an error count and the first failing vector, so the stimulus-and-check sequence runs in hardware on the board instead of only in simulation.

## Interface

Parameters:
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling; legal range ≥1.
- ERR_W, default 4: width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- a_o  out  1  adder input a (vector bit 2).
- b_o  out  1  adder input b (vector bit 1).
- c_o  out  1  adder carry-in (vector bit 0).
- sum_i  in  1  adder sum output.
- carry_i  in  1  adder carry output.
- busy  out  1  high from the cycle after start is accepted through the FINISH cycle.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  1 if the last run had zero mismatches; held until the next start.
- err_cnt  out  ERR_W  mismatching vectors in the last run; saturates at all-ones.
- first_fail_vec  out  3  {a,b,cin} of the first mismatching vector.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

## Operation

- Reset value of all outputs is 0.
  - Reset aborts any run immediately and returns the FSM to IDLE.
- FSM states: IDLE, SETTLE, CHECK, FINISH.
- IDLE:
  - a_o/b_o/c_o = 000; busy = 0.
  - When start = 1, the FSM clears err_cnt, pass, first_fail_vec and first_fail_valid.
  - It sets the vector register vec = 0 and the settle counter = 0, then goes to SETTLE.
- SETTLE:
  - {a_o,b_o,c_o} = vec, registered, so it is stable for the whole state.
  - The FSM stays in SETTLE for SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK:
  - {a_o,b_o,c_o} is still driven.
  - At the closing edge the FSM samples sum_i/carry_i.
  - Expected sum = a^b^c; expected carry = ab | ac | bc.
  - On a mismatch in either bit, err_cnt increments (saturating).
  - On the first mismatch of the run, first_fail_vec ← vec and first_fail_valid ← 1.
  - If vec = 7, go to FINISH; otherwise vec ← vec+1, reset the settle counter, and go to SETTLE.
- FINISH:
  - done = 1 for exactly this cycle; pass = (err_cnt == 0), registered here.
  - Next state is IDLE.
- start is ignored in SETTLE, CHECK and FINISH; no queuing.
- Results (pass, err_cnt, first_fail_*) persist in IDLE until the next accepted start.
- Vector order is fixed ascending 000→111, with a as the MSB.

## Timing

- Edge 0: start is sampled high in IDLE.
- Vector k (k = 0..7) is driven after edge k·(SETTLE_CYCLES+1).
  - It is compared at edge (k+1)·(SETTLE_CYCLES+1).
- FINISH (done = 1) is the cycle after edge 8·(SETTLE_CYCLES+1).
  - With the default of 2, that is edge 24; done falls at edge 25.
- The err_cnt/first_fail update is visible the cycle after the CHECK edge; pass is valid together with done.
- busy rises after edge 0 and falls after the FINISH cycle, coincident with the return to IDLE.
- start held continuously: it is accepted again in the first IDLE cycle after FINISH, giving back-to-back runs separated by one IDLE cycle.
- Asynchronous rst_n assertion mid-run forces outputs to 0 within the same cycle; deassertion resumes in IDLE.

## Test plan

- Correct full-adder model, SETTLE_CYCLES = 2, one start pulse:
  - a/b/c steps through 000..111, each held 3 cycles.
  - done pulses once at edge 24→25; pass = 1, err_cnt = 0, first_fail_valid = 0.
- Carry stuck-at-0 fault:
  - err_cnt = 4 (vectors 3, 5, 6, 7); first_fail_vec = 3'b011; pass = 0.
- Inverted sum:
  - err_cnt = 8; first_fail_vec = 3'b000; pass = 0.
- ERR_W = 2 with inverted sum:
  - err_cnt saturates at 3.
- start pulsed again during vector 3:
  - ignored; the run timing is unchanged and done pulses once.
- rst_n low during vector 4 of a faulty run, then a new start with a correct model:
  - all outputs read 0 during reset.
  - The second run reports pass = 1 and err_cnt = 0, with no stale first_fail.
- SETTLE_CYCLES = 1:
  - each vector is held 2 cycles; done is high in the cycle after edge 16.
